// File: rtl/enc_dec_pkg.sv
// Shared definitions for the extended Hamming(16,11) SECDED encoders and decoder:
// code layout, status encoding and parity helper functions.
package enc_dec_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 16;
  localparam int SYN_W  = 4;

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_CORR = 2'b01,
    ST_DUE  = 2'b10
  } status_e;

  // Code position of each data bit; positions 0,1,2,4,8 carry parity.
  localparam logic [SYN_W-1:0] DATA_POS [DATA_W] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  // Positions whose index has syndrome bit k set.
  localparam logic [CODE_W-1:0] SYN_MASK [SYN_W] = '{
    16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00
  };

  function automatic logic syn_parity(input logic [CODE_W-1:0] code, input int k);
    return ^(code & SYN_MASK[k]);
  endfunction

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int j = 0; j < DATA_W; j++) begin
      d[j] = code[DATA_POS[j]];
    end
    return d;
  endfunction

  // Data-bit mask for a single error at code position syn (empty for parity positions).
  function automatic logic [DATA_W-1:0] data_flip_mask(input logic [SYN_W-1:0] syn);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int j = 0; j < DATA_W; j++) begin
      m[j] = (DATA_POS[j] == syn);
    end
    return m;
  endfunction

endpackage

// File: rtl/dec_syndrome_16.sv
// Combinational Hamming syndrome and overall parity of a 16-bit extended codeword.
module dec_syndrome_16
  import enc_dec_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [SYN_W-1:0]  o_syn,
  output logic              o_par
);

  // Syndrome bits and whole-word parity.
  always_comb begin
    o_syn = '0;
    for (int k = 0; k < SYN_W; k++) begin
      o_syn[k] = syn_parity(i_code, k);
    end
    o_par = ^i_code;
  end

endmodule

// File: rtl/dec_secded_16.sv
// Two-stage valid/ready SECDED decoder for the extended Hamming(16,11) code.
// Optional saturating error counters are built when DEC_ERR_CNT_EN is defined.
module dec_secded_16
  import enc_dec_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_status,
  output logic [SYN_W-1:0]  out_err_pos,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  due_cnt
);

  logic [SYN_W-1:0]  w_syn;
  logic              w_par;
  logic              w_out_fire;
  logic              w_s1_moves;
  logic              w_in_fire;
  logic [DATA_W-1:0] w_dec_data;
  status_e           w_dec_status;
  logic [SYN_W-1:0]  w_dec_pos;

  // Stage 1 keeps only the data bits; parity bits are fully summarised by syndrome and p.
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_data;
  logic [SYN_W-1:0]  r_s1_syn;
  logic              r_s1_par;
  logic              r_s1_en;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  status_e           r_out_status;
  logic [SYN_W-1:0]  r_out_err_pos;

  dec_syndrome_16 u_syn (
    .i_code (in_code),
    .o_syn  (w_syn),
    .o_par  (w_par)
  );

  assign w_out_fire = r_out_valid && out_ready;
  assign w_s1_moves = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready   = !r_s1_valid || w_s1_moves;
  assign w_in_fire  = in_valid && in_ready;

  // Stage 1: capture incoming word with its syndrome, parity and enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_syn   <= '0;
      r_s1_par   <= 1'b0;
      r_s1_en    <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= extract_data(in_code);
      r_s1_syn   <= w_syn;
      r_s1_par   <= w_par;
      r_s1_en    <= en;
    end else if (w_s1_moves) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Classify and correct the stage-1 word.
  always_comb begin
    w_dec_data   = r_s1_data;
    w_dec_status = ST_OK;
    w_dec_pos    = '0;
    if (!r_s1_en) begin
      w_dec_status = ST_OK;
    end else if (r_s1_par) begin
      w_dec_data   = r_s1_data ^ data_flip_mask(r_s1_syn);
      w_dec_status = ST_CORR;
      w_dec_pos    = r_s1_syn;
    end else if (r_s1_syn != 4'd0) begin
      w_dec_status = ST_DUE;
    end else begin
      w_dec_status = ST_OK;
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_status  <= ST_OK;
      r_out_err_pos <= '0;
    end else if (w_s1_moves) begin
      r_out_valid   <= 1'b1;
      r_out_data    <= w_dec_data;
      r_out_status  <= w_dec_status;
      r_out_err_pos <= w_dec_pos;
    end else if (w_out_fire) begin
      r_out_valid   <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_status  = r_out_status;
  assign out_err_pos = r_out_err_pos;

`ifdef DEC_ERR_CNT_EN
  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_due_cnt;

  // Saturating error counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_corr_cnt <= '0;
      r_due_cnt  <= '0;
    end else if (clr_cnt) begin
      r_corr_cnt <= '0;
      r_due_cnt  <= '0;
    end else if (w_out_fire) begin
      case (r_out_status)
        ST_CORR: begin
          if (r_corr_cnt != {CNT_W{1'b1}}) begin
            r_corr_cnt <= r_corr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DUE: begin
          if (r_due_cnt != {CNT_W{1'b1}}) begin
            r_due_cnt <= r_due_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_corr_cnt <= r_corr_cnt;
        end
      endcase
    end
  end

  assign corr_cnt = r_corr_cnt;
  assign due_cnt  = r_due_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_cnt;
  assign corr_cnt     = '0;
  assign due_cnt      = '0;
`endif

endmodule

// File: tb/tb_dec_secded_16.sv
// Directed self-checking bench for dec_secded_16 (counter expectations follow DEC_ERR_CNT_EN).
module tb_dec_secded_16;

`ifdef DEC_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam logic [15:0] CODE_5A5 = 16'hB44B;  // clean codeword of 11'h5A5

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_code = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [10:0] out_data;
  logic [1:0]  out_status;
  logic [3:0]  out_err_pos;
  logic        clr_cnt = 1'b0;
  logic [15:0] corr_cnt;
  logic [15:0] due_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_corr = 0;
  int exp_due  = 0;

  dec_secded_16 #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_status(out_status), .out_err_pos(out_err_pos),
    .clr_cnt(clr_cnt), .corr_cnt(corr_cnt), .due_cnt(due_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    logic px;
    c = 16'h0000;
    c[3] = d[0];  c[5] = d[1];  c[6] = d[2];  c[7] = d[3];
    c[9] = d[4];  c[10] = d[5]; c[11] = d[6]; c[12] = d[7];
    c[13] = d[8]; c[14] = d[9]; c[15] = d[10];
    for (int k = 0; k < 4; k++) begin
      px = 1'b0;
      for (int i = 1; i < 16; i++) begin
        if (((i >> k) & 1) == 1) px = px ^ c[i];
      end
      c[1 << k] = px;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [15:0] exp_cnt(input int n);
    logic [15:0] v;
    v = (n > 65535) ? 16'hFFFF : n[15:0];
    return CNT_ON ? v : 16'h0000;
  endfunction

  // Drives one word into an idle pipeline and returns at the negedge its result is visible.
  task automatic send_and_wait(input logic [15:0] code, input logic e);
    @(negedge clk); in_valid = 1'b1; in_code = code; en = e;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_data !== 11'h000) begin n_fail++; $display("FAIL rst_out_data got=%h exp=000", out_data); end
    n_checks++; if (out_status !== 2'b00 || out_err_pos !== 4'd0) begin n_fail++; $display("FAIL rst_status got=%b/%0d exp=00/0", out_status, out_err_pos); end
    n_checks++; if (corr_cnt !== 16'h0000 || due_cnt !== 16'h0000) begin n_fail++; $display("FAIL rst_cnt got=%h/%h exp=0/0", corr_cnt, due_cnt); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_clean;
    send_and_wait(CODE_5A5, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clean_latency out_valid=%b exp=1", out_valid); end
    n_checks++; if (out_data !== 11'h5A5 || out_status !== 2'b00 || out_err_pos !== 4'd0) begin
      n_fail++; $display("FAIL clean_data got=%h/%b/%0d exp=5a5/00/0", out_data, out_status, out_err_pos); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clean_consumed out_valid=%b exp=0", out_valid); end
  endtask

  task automatic test_single;
    send_and_wait(CODE_5A5 ^ 16'h0040, 1'b1);
    n_checks++; if (out_data !== 11'h5A5 || out_status !== 2'b01 || out_err_pos !== 4'd6) begin
      n_fail++; $display("FAIL single_bit6 got=%h/%b/%0d exp=5a5/01/6", out_data, out_status, out_err_pos); end
    exp_corr++;
    @(negedge clk);
    n_checks++; if (corr_cnt !== exp_cnt(exp_corr)) begin n_fail++; $display("FAIL single_corr_cnt got=%h exp=%h", corr_cnt, exp_cnt(exp_corr)); end
  endtask

  task automatic test_double;
    send_and_wait(CODE_5A5 ^ 16'h0208, 1'b1);
    n_checks++; if (out_data !== 11'h5B4 || out_status !== 2'b10 || out_err_pos !== 4'd0) begin
      n_fail++; $display("FAIL double_3_9 got=%h/%b/%0d exp=5b4/10/0", out_data, out_status, out_err_pos); end
    exp_due++;
    @(negedge clk);
    n_checks++; if (due_cnt !== exp_cnt(exp_due)) begin n_fail++; $display("FAIL double_due_cnt got=%h exp=%h", due_cnt, exp_cnt(exp_due)); end
    n_checks++; if (corr_cnt !== exp_cnt(exp_corr)) begin n_fail++; $display("FAIL double_corr_cnt got=%h exp=%h", corr_cnt, exp_cnt(exp_corr)); end
  endtask

  task automatic test_boundary;
    send_and_wait(CODE_5A5 ^ 16'h0001, 1'b1);
    n_checks++; if (out_data !== 11'h5A5 || out_status !== 2'b01 || out_err_pos !== 4'd0) begin
      n_fail++; $display("FAIL pos0_error got=%h/%b/%0d exp=5a5/01/0", out_data, out_status, out_err_pos); end
    exp_corr++;
    send_and_wait(CODE_5A5 ^ 16'h0040, 1'b0);
    n_checks++; if (out_data !== 11'h5A1 || out_status !== 2'b00 || out_err_pos !== 4'd0) begin
      n_fail++; $display("FAIL en_off_raw got=%h/%b/%0d exp=5a1/00/0", out_data, out_status, out_err_pos); end
    send_and_wait(encode(11'h7FF) ^ 16'h8000, 1'b1);
    n_checks++; if (out_data !== 11'h7FF || out_status !== 2'b01 || out_err_pos !== 4'd15) begin
      n_fail++; $display("FAIL pos15_error got=%h/%b/%0d exp=7ff/01/15", out_data, out_status, out_err_pos); end
    exp_corr++;
    @(negedge clk);
    n_checks++; if (corr_cnt !== exp_cnt(exp_corr)) begin n_fail++; $display("FAIL boundary_corr_cnt got=%h exp=%h", corr_cnt, exp_cnt(exp_corr)); end
  endtask

  task automatic test_back_to_back;
    logic [10:0] wd [8];
    logic [15:0] wc [8];
    logic [1:0]  ws [8];
    logic [3:0]  wp [8];
    int sent, got, pguard, cyc;
    bit saw_block, holding;
    logic [10:0] hold_d;
    logic [1:0]  hold_s;
    wd = '{11'h001, 11'h7FF, 11'h123, 11'h456, 11'h000, 11'h2AA, 11'h555, 11'h3C3};
    for (int i = 0; i < 8; i++) begin
      wc[i] = encode(wd[i]); ws[i] = 2'b00; wp[i] = 4'd0;
    end
    wc[2] = wc[2] ^ 16'h0800; ws[2] = 2'b01; wp[2] = 4'd11;
    exp_corr++;
    sent = 0; got = 0; pguard = 0; cyc = 0; saw_block = 1'b0; holding = 1'b0;
    hold_d = 11'h000; hold_s = 2'b00;
    fork
      begin
        while (sent < 8 && pguard < 200) begin
          @(negedge clk); in_valid = 1'b1; in_code = wc[sent]; en = 1'b1;
          #1;
          if (in_ready) sent++;
          else saw_block = 1'b1;
          pguard++;
        end
        @(negedge clk); in_valid = 1'b0;
      end
      begin
        while (got < 8 && cyc < 200) begin
          @(negedge clk);
          if (holding) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== hold_d || out_status !== hold_s) begin
              n_fail++; $display("FAIL b2b_stable got=%b/%h/%b exp=1/%h/%b", out_valid, out_data, out_status, hold_d, hold_s); end
          end
          out_ready = !(cyc >= 3 && cyc <= 5);
          if (out_valid && out_ready) begin
            n_checks++;
            if (out_data !== wd[got] || out_status !== ws[got] || out_err_pos !== wp[got]) begin
              n_fail++; $display("FAIL b2b_word%0d got=%h/%b/%0d exp=%h/%b/%0d", got, out_data, out_status, out_err_pos, wd[got], ws[got], wp[got]); end
            got++; holding = 1'b0;
          end else if (out_valid) begin
            holding = 1'b1; hold_d = out_data; hold_s = out_status;
          end else begin
            holding = 1'b0;
          end
          cyc++;
        end
        out_ready = 1'b1;
      end
    join
    n_checks++; if (sent != 8 || got != 8) begin n_fail++; $display("FAIL b2b_count sent=%0d got=%0d exp=8/8", sent, got); end
    n_checks++; if (saw_block !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_low saw=%b exp=1", saw_block); end
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_dup out_valid=%b exp=0", out_valid); end
    n_checks++; if (corr_cnt !== exp_cnt(exp_corr)) begin n_fail++; $display("FAIL b2b_corr_cnt got=%h exp=%h", corr_cnt, exp_cnt(exp_corr)); end
  endtask

  task automatic test_reset_inflight;
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_code = encode(11'h111); en = 1'b1;
    @(negedge clk); in_code = encode(11'h222);
    @(negedge clk); in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 11'h111) begin n_fail++; $display("FAIL inflight_setup got=%b/%h exp=1/111", out_valid, out_data); end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 11'h000) begin n_fail++; $display("FAIL inflight_rst got=%b/%h exp=0/000", out_valid, out_data); end
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b1 || corr_cnt !== 16'h0000) begin n_fail++; $display("FAIL inflight_release got=%b/%h exp=1/0000", in_ready, corr_cnt); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_ghost cyc=%0d out_valid=%b exp=0", i, out_valid); end
    end
    exp_corr = 0; exp_due = 0;
  endtask

  task automatic test_saturate;
    int n;
    n = CNT_ON ? 65540 : 4;
    @(negedge clk); clr_cnt = 1'b1;
    @(negedge clk); clr_cnt = 1'b0;
    n_checks++; if (corr_cnt !== 16'h0000 || due_cnt !== 16'h0000) begin n_fail++; $display("FAIL clr_cnt got=%h/%h exp=0/0", corr_cnt, due_cnt); end
    for (int i = 0; i < n; i++) begin
      @(negedge clk); in_valid = 1'b1; in_code = CODE_5A5 ^ 16'h0040; en = 1'b1;
    end
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (corr_cnt !== exp_cnt(n)) begin n_fail++; $display("FAIL sat_corr_cnt got=%h exp=%h", corr_cnt, exp_cnt(n)); end
    @(negedge clk); in_valid = 1'b1; in_code = CODE_5A5 ^ 16'h0040;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); clr_cnt = 1'b1;
    n_checks++; if (out_valid !== 1'b1 || out_status !== 2'b01) begin n_fail++; $display("FAIL clr_collide_setup got=%b/%b exp=1/01", out_valid, out_status); end
    @(negedge clk); clr_cnt = 1'b0;
    n_checks++; if (corr_cnt !== 16'h0000) begin n_fail++; $display("FAIL clr_priority got=%h exp=0000", corr_cnt); end
  endtask

  initial begin
    test_reset;
    test_clean;
    test_single;
    test_double;
    test_boundary;
    test_back_to_back;
    test_reset_inflight;
    test_saturate;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
